// File: rtl/xadc_token_sched_if.sv
// Host/NI-chain bundle for the XADC token scheduler: run control in, token/status out.
interface xadc_token_sched_if #(
  parameter int NUM_NI = 4,
  parameter int IDX_W  = 2
);
  logic              Enable_i;
  logic [15:0]       Period_i;
  logic [NUM_NI-1:0] Mask_i;
  logic [NUM_NI-1:0] TokenDone_i;
  logic [NUM_NI-1:0] Token_o;
  logic [IDX_W-1:0]  CurId_o;
  logic              Busy_o;
  logic              RoundDone_o;
  logic [15:0]       RoundCnt_o;
  logic              Timeout_o;

  modport master (
    output Enable_i, Period_i, Mask_i, TokenDone_i,
    input  Token_o, CurId_o, Busy_o, RoundDone_o, RoundCnt_o, Timeout_o
  );

  modport slave (
    input  Enable_i, Period_i, Mask_i, TokenDone_i,
    output Token_o, CurId_o, Busy_o, RoundDone_o, RoundCnt_o, Timeout_o
  );
endinterface

// File: rtl/xadc_token_sched.sv
// Round-robin token scheduler polling sensor NIs on a chain; one token outstanding at a time.
// Define XADC_SCHED_TIMEOUT_EN to add the HOLD watchdog (TIMEOUT_CYC cycles, Timeout_o pulse).
module xadc_token_sched #(
  parameter int NUM_NI      = 4,
  parameter int IDX_W       = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic               clk,
  input logic               rst,
  xadc_token_sched_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SCAN,
    ST_ISSUE,
    ST_HOLD
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NI - 1);

  if (NUM_NI < 2 || NUM_NI > 16 || IDX_W != $clog2(NUM_NI) || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("xadc_token_sched: illegal NUM_NI/IDX_W/TIMEOUT_CYC combination");
  end

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [15:0]       per_cnt_q, per_cnt_d;
  logic [15:0]       round_cnt_q, round_cnt_d;
  logic              round_done_q, round_done_d;
  logic              advance;
  logic              to_idle;
  logic              hold_exit;
  logic              node_done;
  logic [NUM_NI-1:0] token;
  logic              busy;

`ifdef XADC_SCHED_TIMEOUT_EN
  localparam int HC_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [HC_W-1:0] HC_LIMIT = HC_W'(TIMEOUT_CYC);
  localparam logic [HC_W-1:0] HC_WARN  = HC_W'(TIMEOUT_CYC - 1);

  logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
  logic            timeout_q, timeout_d;
`endif

  // Only the bit of the node currently holding the token matters.
  assign node_done = bus.TokenDone_i[idx_q];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      per_cnt_q    <= '0;
      round_cnt_q  <= '0;
      round_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      per_cnt_q    <= per_cnt_d;
      round_cnt_q  <= round_cnt_d;
      round_done_q <= round_done_d;
    end
  end

`ifdef XADC_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end
`endif

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    per_cnt_d    = per_cnt_q;
    round_cnt_d  = round_cnt_q;
    round_done_d = 1'b0;
    advance      = 1'b0;
    to_idle      = 1'b0;
    hold_exit    = node_done;
`ifdef XADC_SCHED_TIMEOUT_EN
    hold_cnt_d   = hold_cnt_q;
    timeout_d    = 1'b0;
    // The limit cycle is the one showing the Timeout_o pulse; leave HOLD right after it.
    if (hold_cnt_q == HC_LIMIT) begin
      hold_exit = 1'b1;
    end
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.Enable_i) begin
          state_d   = ST_WAIT;
          per_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        // Period_i compared live; a counter already past it runs on to the 16-bit wrap.
        if (!bus.Enable_i) begin
          to_idle = 1'b1;
        end else if (per_cnt_q == bus.Period_i) begin
          state_d   = ST_SCAN;
          idx_d     = '0;
          per_cnt_d = '0;
        end else begin
          per_cnt_d = per_cnt_q + 16'd1;
        end
      end
      ST_SCAN: begin
        if (!bus.Enable_i) begin
          to_idle = 1'b1;
        end else if (bus.Mask_i[idx_q]) begin
          state_d = ST_ISSUE;
        end else begin
          advance = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_HOLD;
`ifdef XADC_SCHED_TIMEOUT_EN
        hold_cnt_d = '0;
`endif
      end
      ST_HOLD: begin
        // A node that owns the token is always allowed to finish, even after Enable_i drops.
        if (hold_exit) begin
          if (bus.Enable_i) begin
            advance = 1'b1;
          end else begin
            to_idle = 1'b1;
          end
        end
`ifdef XADC_SCHED_TIMEOUT_EN
        else begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
          timeout_d  = (hold_cnt_q == HC_WARN);
        end
`endif
      end
      default: begin
        to_idle = 1'b1;
      end
    endcase

    if (to_idle) begin
      state_d   = ST_IDLE;
      idx_d     = '0;
      per_cnt_d = '0;
    end

    if (advance) begin
      if (idx_q == LAST_IDX) begin
        state_d      = ST_WAIT;
        idx_d        = '0;
        per_cnt_d    = '0;
        round_cnt_d  = round_cnt_q + 16'd1;
        round_done_d = 1'b1;
      end else begin
        state_d = ST_SCAN;
        idx_d   = idx_q + IDX_W'(1);
      end
    end
  end

  // Moore outputs, decoded from registered state only.
  always_comb begin
    token = '0;
    busy  = 1'b0;
    unique case (state_q)
      ST_SCAN, ST_HOLD: begin
        busy = 1'b1;
      end
      ST_ISSUE: begin
        busy         = 1'b1;
        token[idx_q] = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign bus.Token_o     = token;
  assign bus.CurId_o     = idx_q;
  assign bus.Busy_o      = busy;
  assign bus.RoundDone_o = round_done_q;
  assign bus.RoundCnt_o  = round_cnt_q;
`ifdef XADC_SCHED_TIMEOUT_EN
  assign bus.Timeout_o   = timeout_q;
`else
  assign bus.Timeout_o   = 1'b0;
`endif

  a_token_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.Token_o));
  a_token_in_issue: assert property (@(posedge clk) disable iff (rst)
                                     (bus.Token_o != '0) |-> (state_q == ST_ISSUE));

endmodule

// File: tb/tb_xadc_token_sched.sv
// Directed bench for xadc_token_sched: round order, masking, enable drop, watchdog, reset.
module tb_xadc_token_sched;
  localparam int NUM_NI      = 4;
  localparam int IDX_W       = 2;
  localparam int TIMEOUT_CYC = 16;

  logic              clk = 1'b0;
  logic              rst;
  int                total = 0;
  int                bad   = 0;
  logic [NUM_NI-1:0] done_man  = '0;
  logic [NUM_NI-1:0] done_resp = '0;
  bit                resp_en   = 1'b0;
  int                resp_cnt  = 0;
  int                resp_node = 0;

  xadc_token_sched_if #(.NUM_NI(NUM_NI), .IDX_W(IDX_W)) bus ();
  assign bus.TokenDone_i = done_man | done_resp;

  xadc_token_sched #(
    .NUM_NI(NUM_NI),
    .IDX_W(IDX_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // NI model: pulses TokenDone for the served node 6 cycles after its token is seen.
  always begin
    @(posedge clk);
    #1;
    done_resp = '0;
    if (resp_en) begin
      if (bus.Token_o != '0) begin
        for (int i = 0; i < NUM_NI; i++) if (bus.Token_o[i]) resp_node = i;
        resp_cnt = 6;
      end else if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) done_resp[resp_node] = 1'b1;
      end
    end else begin
      resp_cnt = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.Enable_i = 1'b0; done_man = '0; resp_en = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.Enable_i = 1'b1; bus.Period_i = 16'd0; bus.Mask_i = 4'hF; done_man = 4'hF;
    step(); step(); step();
    total++; if (bus.Token_o !== 4'b0) begin bad++; $display("FAIL reset_token got=%b want=0000", bus.Token_o); end
    total++; if (bus.Busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.Busy_o); end
    total++; if (bus.CurId_o !== 2'd0) begin bad++; $display("FAIL reset_curid got=%0d want=0", bus.CurId_o); end
    total++; if (bus.RoundCnt_o !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", bus.RoundCnt_o); end
    total++; if (bus.RoundDone_o !== 1'b0) begin bad++; $display("FAIL reset_rd got=%b want=0", bus.RoundDone_o); end
    total++; if (bus.Timeout_o !== 1'b0) begin bad++; $display("FAIL reset_to got=%b want=0", bus.Timeout_o); end
    bus.Enable_i = 1'b0; done_man = '0; rst = 1'b0;
    step(); step();
    total++; if (bus.Busy_o !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", bus.Busy_o); end
  endtask

  task automatic test_full_round();
    logic [3:0]  exp_tok;
    logic        exp_busy;
    logic [15:0] exp_cnt;
    do_reset();
    bus.Mask_i = 4'hF; bus.Period_i = 16'd3; bus.Enable_i = 1'b1; resp_en = 1'b1;
    for (int n = 1; n <= 52; n++) begin
      step();
      exp_tok  = (n == 6)  ? 4'b0001 : (n == 14) ? 4'b0010 : (n == 22) ? 4'b0100 :
                 (n == 30) ? 4'b1000 : (n == 42) ? 4'b0001 : 4'b0000;
      exp_busy = (n >= 5 && n <= 36) || (n >= 41 && n <= 48);
      exp_cnt  = (n >= 37) ? 16'd1 : 16'd0;
      total++; if (bus.Token_o !== exp_tok) begin bad++; $display("FAIL full_tok n=%0d got=%b want=%b", n, bus.Token_o, exp_tok); end
      total++; if (bus.Busy_o !== exp_busy) begin bad++; $display("FAIL full_busy n=%0d got=%b want=%b", n, bus.Busy_o, exp_busy); end
      total++; if (bus.RoundDone_o !== (n == 37)) begin bad++; $display("FAIL full_rd n=%0d got=%b", n, bus.RoundDone_o); end
      total++; if (bus.RoundCnt_o !== exp_cnt) begin bad++; $display("FAIL full_cnt n=%0d got=%0d want=%0d", n, bus.RoundCnt_o, exp_cnt); end
      if (n == 41) begin
        total++; if (bus.CurId_o !== 2'd0) begin bad++; $display("FAIL full_restart_id got=%0d want=0", bus.CurId_o); end
      end
      if (n == 42) bus.Enable_i = 1'b0;
    end
    resp_en = 1'b0;
  endtask

  task automatic test_mask_0101();
    logic [3:0] exp_tok;
    logic       exp_busy;
    int         rd_seen;
    rd_seen = 0;
    do_reset();
    bus.Mask_i = 4'b0101; bus.Period_i = 16'd0; bus.Enable_i = 1'b1; resp_en = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      step();
      exp_tok  = (n == 3) ? 4'b0001 : (n == 12) ? 4'b0100 : 4'b0000;
      exp_busy = (n >= 2 && n <= 19) || (n == 21);
      if (bus.RoundDone_o === 1'b1) rd_seen++;
      total++; if (bus.Token_o !== exp_tok) begin bad++; $display("FAIL mask_tok n=%0d got=%b want=%b", n, bus.Token_o, exp_tok); end
      total++; if (bus.Busy_o !== exp_busy) begin bad++; $display("FAIL mask_busy n=%0d got=%b want=%b", n, bus.Busy_o, exp_busy); end
      total++; if (bus.RoundDone_o !== (n == 20)) begin bad++; $display("FAIL mask_rd n=%0d got=%b", n, bus.RoundDone_o); end
      if (n == 10) begin total++; if (bus.CurId_o !== 2'd1) begin bad++; $display("FAIL mask_scan1 got=%0d want=1", bus.CurId_o); end end
      if (n == 11) begin total++; if (bus.CurId_o !== 2'd2) begin bad++; $display("FAIL mask_scan2 got=%0d want=2", bus.CurId_o); end end
      if (n == 19) begin total++; if (bus.CurId_o !== 2'd3) begin bad++; $display("FAIL mask_scan3 got=%0d want=3", bus.CurId_o); end end
      if (n == 21) bus.Enable_i = 1'b0;
    end
    total++; if (bus.RoundCnt_o !== 16'd1) begin bad++; $display("FAIL mask_cnt got=%0d want=1", bus.RoundCnt_o); end
    total++; if (rd_seen != 1) begin bad++; $display("FAIL mask_rd_count got=%0d want=1", rd_seen); end
    resp_en = 1'b0;
  endtask

  task automatic test_all_masked();
    logic [15:0] exp_cnt;
    logic        exp_busy;
    do_reset();
    bus.Mask_i = 4'b0000; bus.Period_i = 16'd0; bus.Enable_i = 1'b1;
    for (int n = 1; n <= 22; n++) begin
      step();
      exp_cnt  = (n >= 6) ? 16'((n - 6) / 5 + 1) : 16'd0;
      exp_busy = (n >= 2) && ((n - 1) % 5 != 0);
      total++; if (bus.Token_o !== 4'b0) begin bad++; $display("FAIL allm_tok n=%0d got=%b want=0000", n, bus.Token_o); end
      total++; if (bus.Busy_o !== exp_busy) begin bad++; $display("FAIL allm_busy n=%0d got=%b want=%b", n, bus.Busy_o, exp_busy); end
      total++; if (bus.RoundDone_o !== (n >= 6 && (n - 6) % 5 == 0)) begin bad++; $display("FAIL allm_rd n=%0d got=%b", n, bus.RoundDone_o); end
      total++; if (bus.RoundCnt_o !== exp_cnt) begin bad++; $display("FAIL allm_cnt n=%0d got=%0d want=%0d", n, bus.RoundCnt_o, exp_cnt); end
    end
    bus.Enable_i = 1'b0;
  endtask

  task automatic test_enable_drop_hold();
    logic [3:0] exp_tok;
    logic       exp_busy;
    do_reset();
    bus.Mask_i = 4'hF; bus.Period_i = 16'd0; bus.Enable_i = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      exp_tok  = (n == 3) ? 4'b0001 : (n == 6) ? 4'b0010 : (n == 9) ? 4'b0100 : 4'b0000;
      exp_busy = (n >= 2 && n <= 14);
      total++; if (bus.Token_o !== exp_tok) begin bad++; $display("FAIL drop_tok n=%0d got=%b want=%b", n, bus.Token_o, exp_tok); end
      total++; if (bus.Busy_o !== exp_busy) begin bad++; $display("FAIL drop_busy n=%0d got=%b want=%b", n, bus.Busy_o, exp_busy); end
      if (n >= 10 && n <= 14) begin
        total++; if (bus.CurId_o !== 2'd2) begin bad++; $display("FAIL drop_hold_id n=%0d got=%0d want=2", n, bus.CurId_o); end
      end
      case (n)
        4:  done_man = 4'b0001;
        7:  done_man = 4'b0010;
        10: bus.Enable_i = 1'b0;
        11: done_man = 4'b1010;
        14: done_man = 4'b0100;
        default: done_man = 4'b0000;
      endcase
    end
    total++; if (bus.RoundCnt_o !== 16'd0) begin bad++; $display("FAIL drop_cnt got=%0d want=0", bus.RoundCnt_o); end
  endtask

  task automatic test_timeout();
    logic [3:0] exp_tok;
    do_reset();
    bus.Mask_i = 4'hF; bus.Period_i = 16'd0; bus.Enable_i = 1'b1;
`ifdef XADC_SCHED_TIMEOUT_EN
    for (int n = 1; n <= 26; n++) begin
      step();
      exp_tok = (n == 3) ? 4'b0001 : (n == 6) ? 4'b0010 : (n == 25) ? 4'b0100 : 4'b0000;
      total++; if (bus.Token_o !== exp_tok) begin bad++; $display("FAIL to_tok n=%0d got=%b want=%b", n, bus.Token_o, exp_tok); end
      total++; if (bus.Timeout_o !== (n == 23)) begin bad++; $display("FAIL to_pulse n=%0d got=%b", n, bus.Timeout_o); end
      if (n == 23) begin
        total++; if (bus.CurId_o !== 2'd1) begin bad++; $display("FAIL to_id got=%0d want=1", bus.CurId_o); end
      end
      done_man = (n == 4) ? 4'b0001 : 4'b0000;
    end
`else
    for (int n = 1; n <= 40; n++) begin
      step();
      exp_tok = (n == 3) ? 4'b0001 : (n == 6) ? 4'b0010 : 4'b0000;
      total++; if (bus.Token_o !== exp_tok) begin bad++; $display("FAIL nto_tok n=%0d got=%b want=%b", n, bus.Token_o, exp_tok); end
      total++; if (bus.Timeout_o !== 1'b0) begin bad++; $display("FAIL nto_pulse n=%0d got=%b want=0", n, bus.Timeout_o); end
      done_man = (n == 4) ? 4'b0001 : 4'b0000;
    end
    total++; if (bus.CurId_o !== 2'd1) begin bad++; $display("FAIL nto_id got=%0d want=1", bus.CurId_o); end
    total++; if (bus.Busy_o !== 1'b1) begin bad++; $display("FAIL nto_busy got=%b want=1", bus.Busy_o); end
`endif
    bus.Enable_i = 1'b0;
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    bus.Mask_i = 4'b0000; bus.Period_i = 16'd0; bus.Enable_i = 1'b1;
    for (int n = 1; n <= 31; n++) begin
      step();
      if (n == 26) begin
        total++; if (bus.RoundCnt_o !== 16'd5) begin bad++; $display("FAIL rih_cnt5 got=%0d want=5", bus.RoundCnt_o); end
        bus.Mask_i = 4'hF;
      end
    end
    total++; if (bus.Busy_o !== 1'b1) begin bad++; $display("FAIL rih_hold_busy got=%b want=1", bus.Busy_o); end
    total++; if (bus.Token_o !== 4'b0) begin bad++; $display("FAIL rih_hold_tok got=%b want=0000", bus.Token_o); end
    rst = 1'b1;
    step();
    rst = 1'b0; bus.Enable_i = 1'b0;
    total++; if (bus.Busy_o !== 1'b0) begin bad++; $display("FAIL rih_busy got=%b want=0", bus.Busy_o); end
    total++; if (bus.RoundCnt_o !== 16'd0) begin bad++; $display("FAIL rih_cnt got=%0d want=0", bus.RoundCnt_o); end
    total++; if (bus.CurId_o !== 2'd0) begin bad++; $display("FAIL rih_id got=%0d want=0", bus.CurId_o); end
    total++; if (bus.Token_o !== 4'b0) begin bad++; $display("FAIL rih_tok got=%b want=0000", bus.Token_o); end
    total++; if (bus.RoundDone_o !== 1'b0) begin bad++; $display("FAIL rih_rd got=%b want=0", bus.RoundDone_o); end
    total++; if (bus.Timeout_o !== 1'b0) begin bad++; $display("FAIL rih_to got=%b want=0", bus.Timeout_o); end
    for (int n = 0; n < 4; n++) begin
      done_man = (n % 2 == 0) ? 4'hF : 4'h0;
      step();
      total++; if (bus.Busy_o !== 1'b0) begin bad++; $display("FAIL stray_busy n=%0d got=%b want=0", n, bus.Busy_o); end
      total++; if (bus.Token_o !== 4'b0) begin bad++; $display("FAIL stray_tok n=%0d got=%b want=0000", n, bus.Token_o); end
      total++; if (bus.RoundCnt_o !== 16'd0) begin bad++; $display("FAIL stray_cnt n=%0d got=%0d want=0", n, bus.RoundCnt_o); end
    end
    done_man = '0;
  endtask

  initial begin
    rst = 1'b1;
    bus.Enable_i = 1'b0;
    bus.Period_i = 16'd0;
    bus.Mask_i   = '0;
    test_reset();
    test_full_round();
    test_mask_0101();
    test_all_masked();
    test_enable_drop_hold();
    test_timeout();
    test_reset_in_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/xadc_token_sched.md
XADC_TOKEN_SCHED -- requirements
Module: xadc_token_sched

Interface
REQ-001 SHALL have parameter NUM_NI, default 4, number of sensor NIs on the token chain (legal 2..16).
REQ-002 SHALL have parameter IDX_W, default 2, width of node index, equal to clog2(NUM_NI).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, watchdog limit in cycles (used only with REQ-030).
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 Enable_i  input  1  scheduler run enable.
REQ-007 Period_i  input  16  idle cycles between end of one round and start of next.
REQ-008 Mask_i  input  NUM_NI  per-node participation, 1 = node is polled.
REQ-009 TokenDone_i  input  NUM_NI  token-return pulse from each NI (its TokenValid_o).
REQ-010 Token_o  output  NUM_NI  one-hot single-cycle token to NI TokenValid_i.
REQ-011 CurId_o  output  IDX_W  index of node currently being scanned or served.
REQ-012 Busy_o  output  1  high while a round is in progress.
REQ-013 RoundDone_o  output  1  single-cycle pulse at round completion.
REQ-014 RoundCnt_o  output  16  completed-round counter.
REQ-015 Timeout_o  output  1  single-cycle pulse when a node fails to return its token.

Function
REQ-016 SHALL implement Moore FSM with states IDLE, WAIT, SCAN, ISSUE, HOLD; Token_o, Busy_o decoded from registered state only.
REQ-017 IDLE: Enable_i=1 -> WAIT with period counter cleared; else stay.
REQ-018 WAIT: period counter increments each cycle; counter==Period_i -> SCAN with idx=0, counter cleared; Period_i=0 -> SCAN on first WAIT cycle.
REQ-019 SCAN: Mask_i[idx]=1 -> ISSUE; Mask_i[idx]=0 -> advance (REQ-022) in one cycle; Mask_i sampled per index, not latched per round.
REQ-020 ISSUE: Token_o = one-hot(idx) for exactly this one cycle; -> HOLD unconditionally; TokenDone_i ignored in ISSUE.
REQ-021 HOLD: TokenDone_i[idx]=1 -> advance; TokenDone_i bits other than idx ignored in every state.
REQ-022 Advance: idx<NUM_NI-1 -> SCAN with idx+1; idx==NUM_NI-1 -> WAIT, RoundDone_o pulse next cycle, RoundCnt_o +1 (wraps 0xFFFF->0), idx=0.
REQ-023 All nodes masked: round still completes after NUM_NI SCAN cycles and increments RoundCnt_o.
REQ-024 Enable_i=0 in WAIT or SCAN -> IDLE next cycle, round abandoned, RoundCnt_o unchanged.
REQ-025 Enable_i=0 in ISSUE or HOLD -> current node served to completion (no packet truncation), then IDLE instead of advance.
REQ-026 Busy_o=1 in SCAN, ISSUE, HOLD; 0 in IDLE, WAIT.
REQ-027 Period_i sampled every WAIT cycle; a change mid-WAIT takes effect immediately (counter>Period_i keeps counting to 0xFFFF wrap -- software must change Period_i only in IDLE).
REQ-028 At most one Token_o bit high at any cycle; never two tokens outstanding.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, idx=0, period counter=0, RoundCnt_o=0, Token_o=0, RoundDone_o=0, Timeout_o=0, Busy_o=0, CurId_o=0; reset mid-HOLD abandons the node silently.

Configuration
REQ-030 Macro XADC_SCHED_TIMEOUT_EN defined: HOLD counter starts at 0 on HOLD entry; reaching TIMEOUT_CYC without TokenDone_i[idx] -> Timeout_o pulse one cycle, then advance as REQ-022; done and timeout on same cycle -> done wins, no pulse.
REQ-031 Macro XADC_SCHED_TIMEOUT_EN undefined: HOLD waits indefinitely, Timeout_o tied 0, no HOLD counter present.

Verification
REQ-032 NUM_NI=4, Mask=4'hF, Period=3, each NI returns done 6 cycles after token -> Token_o 0001,0010,0100,1000 in order, RoundCnt_o=1, next round SCAN starts 4 WAIT cycles after RoundDone_o.
REQ-033 Mask=4'b0101 -> only Token_o 0001 and 0100 issued, SCAN visits idx 1 and 3 one cycle each, RoundDone_o pulses once.
REQ-034 Mask=0, Period=0 -> RoundCnt_o increments every NUM_NI+1 cycles, Token_o stays 0.
REQ-035 Enable_i dropped during HOLD on idx 2 -> FSM stays HOLD until TokenDone_i[2], then IDLE, no token to idx 3, RoundCnt_o unchanged.
REQ-036 With XADC_SCHED_TIMEOUT_EN, TIMEOUT_CYC=16, NI 1 never responds -> Timeout_o pulse 16 cycles after HOLD entry with CurId_o=1, Token_o 0100 follows; without macro FSM remains in HOLD.
REQ-037 rst asserted in HOLD with RoundCnt_o=5 -> next cycle all outputs 0, state IDLE; stray TokenDone_i pulses afterwards have no effect.
